alu_seq: RTL
============

# alu_seq

Multi-cycle command sequencer in front of the 8-bit adder ALU. Accepts one command at a time over a start/busy/done handshake. Executes ADD, SUB, unsigned MUL and accumulate by issuing one or more add passes to the ALU, one pass per clock. Returns an 8-bit result with an overflow flag. Sits between the front-end control logic and the shared ALU instance, and owns all of the ALU's input ports.

## Interface
- No parameters; all datapaths are 8 bits.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- cmd  in  2  command: 00 ADD, 01 SUB, 10 MUL (unsigned), 11 ACC.
- opa  in  8  operand A; latched on an accepted start.
- opb  in  8  operand B; latched on an accepted start.
- acc_clr  in  1  clears the accumulator; honoured only in IDLE.
- busy  out  1  high while a command is executing.
- done  out  1  one-cycle pulse; result and ovf are valid from this cycle on.
- result  out  8  result of the last command; held until the next done.
- ovf  out  1  overflow flag of the last command; held with result.
- alu_op  out  1  ALU op select; driven 0 (add) at all times.
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_c  in  8  ALU sum, combinational from alu_a and alu_b.
- alu_over  in  1  ALU signed-overflow flag.

## Operation
- States:
  - IDLE
  - NEG: SUB first pass
  - EXEC: single add pass
  - DBL: MUL double step
  - MADD: MUL conditional-add step
  - DONE
- IDLE:
  - start=1 latches cmd, opa and opb.
  - ADD and ACC go to EXEC; SUB goes to NEG; MUL clears P (8-bit partial product), sets i=7 and goes to DBL.
  - alu_a and alu_b are driven 0 in IDLE and DONE.
- ADD (EXEC):
  - Drives alu_a=opa, alu_b=opb.
  - Registers result=alu_c and ovf=alu_over.
- SUB:
  - NEG drives alu_a=~opb, alu_b=0x01 and stores negb=alu_c.
  - EXEC drives alu_a=opa, alu_b=negb and registers result=alu_c.
  - ovf=alu_over from EXEC, except when opb==0x80: then ovf=~opa[7].
- MUL:
  - For i=7 down to 0: DBL drives alu_a=P, alu_b=P, then P<=alu_c. MADD drives alu_a=P, alu_b=(opb[i] ? opa : 0x00), then P<=alu_c.
  - Fixed 16 passes; each bit always takes a MADD pass, even when its B bit is 0.
  - Per-pass carry = (x7&y7) | ((x7|y7)&~c7), where x=alu_a, y=alu_b, c=alu_c.
  - ovf is the sticky OR of that carry over all 16 passes, i.e. ovf=1 iff opa*opb > 255.
  - result = low 8 bits of the product.
- ACC (EXEC):
  - Drives alu_a=acc, alu_b=opa.
  - acc<=alu_c, result=alu_c, ovf=alu_over.
  - acc is internal, 8 bits, signed wrap-around. ADD, SUB and MUL never modify it.
- acc_clr in IDLE sets acc=0.
  - If acc_clr and start with cmd=ACC arrive in the same cycle, the clear applies first: the result is 0+opa.
- DONE: done=1, then return to IDLE.

## Timing
- An accepted start is cycle 0; busy=1 from cycle 1 until the last ALU pass.
- done pulses the cycle after the last ALU pass, with busy=0.
- Latency to done:
  - ADD: 2 cycles
  - ACC: 2 cycles
  - SUB: 3 cycles
  - MUL: 17 cycles
- Back-to-back: start can be accepted in the cycle after done, so throughput for ADD is one command per 3 cycles.
- start or acc_clr while state≠IDLE (including DONE) is ignored and not queued. Operand changes while busy have no effect.
- Reset (any state, including mid-operation), next edge:
  - state=IDLE
  - busy=0, done=0
  - result=0x00, ovf=0
  - acc=0x00, P=0
  - alu_a=alu_b=0x00
- No done pulse is produced for an aborted command.

## Test plan
- ADD 0x7F+0x01 → result 0x80, ovf=1, done at cycle 2. ADD 0x10+0x20 → 0x30, ovf=0.
- SUB 0x03−0x05 → 0xFE, ovf=0, done at cycle 3. SUB 0x80−0x01 → 0x7F, ovf=1. SUB 0x05−0x80 → 0x85, ovf=1. SUB 0x85−0x80 → 0x05, ovf=0.
- MUL 15×17 → 0xFF, ovf=0, done at cycle 17. MUL 16×16 → 0x00, ovf=1. MUL 0×0xFF → 0x00, ovf=0. Check the alu_a/alu_b pass sequence against the DBL/MADD rule.
- acc_clr together with start ACC opa=0x70 → 0x70. Then ACC 0x70 → 0xE0, ovf=1. Then ACC 0x20 → 0x00, ovf=0. A SUB in between leaves acc unchanged.
- start pulsed during MUL busy and during DONE → ignored: exactly one done pulse, result unchanged by the ignored request.
- rst asserted at MUL cycle 8 → next cycle busy=0, result=0x00, acc=0x00, no done pulse. A following ADD 0x01+0x01 → 0x02 at cycle 2.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle command sequencer driving a shared 8-bit adder ALU.
// Runs ADD, SUB, unsigned MUL and accumulate as a series of single-cycle add passes.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    input  logic       acc_clr,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       ovf,
    output logic       alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_c,
    input  logic       alu_over
);

    typedef enum logic [2:0] {
        StIdle,
        StNeg,
        StExec,
        StDbl,
        StMadd,
        StDone
    } state_e;

    localparam logic [1:0] CmdAdd = 2'b00;
    localparam logic [1:0] CmdSub = 2'b01;
    localparam logic [1:0] CmdMul = 2'b10;
    localparam logic [1:0] CmdAcc = 2'b11;

    state_e     state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic [7:0] negb_q, negb_d;
    logic [7:0] p_q, p_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] result_q, result_d;
    logic       ovf_q, ovf_d;
    logic       movf_q, movf_d;
    logic       carry;

    // Unsigned carry-out of the current pass, recovered from operand and sum MSBs.
    assign carry = (alu_a[7] & alu_b[7]) | ((alu_a[7] | alu_b[7]) & ~alu_c[7]);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        negb_d   = negb_q;
        p_d      = p_q;
        bit_d    = bit_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        movf_d   = movf_q;
        alu_a    = 8'h00;
        alu_b    = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (acc_clr) begin
                    acc_d = 8'h00;
                end
                if (start) begin
                    cmd_d = cmd;
                    opa_d = opa;
                    opb_d = opb;
                    unique case (cmd)
                        CmdSub: state_d = StNeg;
                        CmdMul: begin
                            p_d     = 8'h00;
                            bit_d   = 3'd7;
                            movf_d  = 1'b0;
                            state_d = StDbl;
                        end
                        default: state_d = StExec;
                    endcase
                end
            end
            StNeg: begin
                alu_a   = ~opb_q;
                alu_b   = 8'h01;
                negb_d  = alu_c;
                state_d = StExec;
            end
            StExec: begin
                unique case (cmd_q)
                    CmdSub: begin
                        alu_a = opa_q;
                        alu_b = negb_q;
                    end
                    CmdAcc: begin
                        alu_a = acc_q;
                        alu_b = opa_q;
                        acc_d = alu_c;
                    end
                    default: begin
                        alu_a = opa_q;
                        alu_b = opb_q;
                    end
                endcase
                result_d = alu_c;
                ovf_d    = alu_over;
                // Negating 0x80 wraps to itself, so the adder flag is wrong for that operand.
                if (cmd_q == CmdSub && opb_q == 8'h80) begin
                    ovf_d = ~opa_q[7];
                end
                state_d = StDone;
            end
            StDbl: begin
                alu_a   = p_q;
                alu_b   = p_q;
                p_d     = alu_c;
                movf_d  = movf_q | carry;
                state_d = StMadd;
            end
            StMadd: begin
                alu_a  = p_q;
                alu_b  = opb_q[bit_q] ? opa_q : 8'h00;
                p_d    = alu_c;
                movf_d = movf_q | carry;
                if (bit_q == 3'd0) begin
                    result_d = alu_c;
                    ovf_d    = movf_q | carry;
                    state_d  = StDone;
                end else begin
                    bit_d   = bit_q - 3'd1;
                    state_d = StDbl;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cmd_q    <= CmdAdd;
            opa_q    <= 8'h00;
            opb_q    <= 8'h00;
            negb_q   <= 8'h00;
            p_q      <= 8'h00;
            bit_q    <= 3'd0;
            acc_q    <= 8'h00;
            result_q <= 8'h00;
            ovf_q    <= 1'b0;
            movf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            negb_q   <= negb_d;
            p_q      <= p_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            movf_q   <= movf_d;
        end
    end

    assign busy   = (state_q == StNeg) || (state_q == StExec) ||
                    (state_q == StDbl) || (state_q == StMadd);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign ovf    = ovf_q;
    assign alu_op = 1'b0;

endmodule
